// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, frame-length derivation and the scan FSM
// state type used by the VGA timing controller.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int CLK_DIV_DEF  = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = scan_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = scan_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate prescaler: counts clk_i cycles while the scan runs and flags the
// last cycle of each pixel period.
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  output logic tick
);

  localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  // Held at zero outside the scan so the first pixel after a start is full length.
  always_comb begin
    cnt_d = '0;
    if (run && !tick) cnt_d = cnt_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: IDLE/RUN/DRAIN scan FSM, pixel/line counters
// and registered sync/blank decode derived from the next-state counters.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic [CNT_W-1:0] pix_x_o,
  output logic [CNT_W-1:0] pix_y_o,
  output logic             tick_o,
  output logic             line_o,
  output logic             frame_o,
  output logic             busy_o
);

  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  vga_state_e       state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
  logic             tick_q, tick_d, line_q, line_d, frame_q, frame_d, busy_q, busy_d;
  logic             run, pix_tick, at_end;

  assign run    = (state_q != ST_IDLE);
  assign at_end = (x_q == H_LAST) && (y_q == V_LAST);

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run   (run),
    .tick  (pix_tick)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tick_d  = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (en_i) begin
          state_d = ST_RUN;
          frame_d = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (pix_tick) begin
          tick_d = 1'b1;
          if (x_q == H_LAST) begin
            x_d    = '0;
            line_d = 1'b1;
            y_d    = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
          end else begin
            x_d = x_q + CNT_W'(1);
          end
        end
        // The frame-wrap tick either starts the next frame or ends the scan quietly.
        if (pix_tick && at_end) begin
          if (state_q == ST_RUN && en_i) begin
            frame_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tick_d  = 1'b0;
            line_d  = 1'b0;
          end
        end else if (state_q == ST_RUN && !en_i) begin
          state_d = ST_DRAIN;
        end else if (state_q == ST_DRAIN && en_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    hsync_d = !(busy_d && in_window(x_d, HS_FIRST, HS_LAST));
    vsync_d = !(busy_d && in_window(y_d, VS_FIRST, VS_LAST));
    video_d = busy_d && (x_d < H_ACT) && (y_d < V_ACT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
      tick_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      tick_q  <= tick_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign video_on_o = video_q;
  assign pix_x_o    = x_q;
  assign pix_y_o    = y_q;
  assign tick_o     = tick_q;
  assign line_o     = line_q;
  assign frame_o    = frame_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a reduced-raster instance exercises the FSM end to end, a
// default 640x480 instance checks pixel/line timing over its first line.
module tb_vga_timing_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i  = 1'b0;

  // Reduced raster: CLK_DIV 2, H 8+2+3+2 = 15, V 6+1+2+1 = 10 -> 30 clk/line, 300 clk/frame.
  logic       d_hs, d_vs, d_vid, d_tick, d_line, d_frame, d_busy;
  logic [9:0] d_x, d_y;
  logic       f_hs, f_vs, f_vid, f_tick, f_line, f_frame, f_busy;
  logic [9:0] f_x, f_y;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  vga_timing_ctrl #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .hsync_o(d_hs), .vsync_o(d_vs), .video_on_o(d_vid),
    .pix_x_o(d_x), .pix_y_o(d_y),
    .tick_o(d_tick), .line_o(d_line), .frame_o(d_frame), .busy_o(d_busy)
  );

  vga_timing_ctrl dut_full (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .hsync_o(f_hs), .vsync_o(f_vs), .video_on_o(f_vid),
    .pix_x_o(f_x), .pix_y_o(f_y),
    .tick_o(f_tick), .line_o(f_line), .frame_o(f_frame), .busy_o(f_busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kc, guard, bad_d, bad_f;
    int last_tick_d, bad_tick_d, n_tick_d, last_line_d, bad_line_d, n_line_d;
    int last_frame_d, bad_frame_d, n_frame_d, first_frame_d;
    int hs_low_d, vs_low_d, vid_d, hs_first_x_d, vs_first_y_d;
    int last_tick_f, bad_tick_f, n_tick_f, n_line_f, line_k_f, n_frame_f;
    int hs_low_f, vs_low_f, vid_f, hs_first_x_f, hs_last_x_f;
    int n_busy_low, n_frame_extra;

    // Asynchronous reset with no clock edge in between
    #2 rst_i = 1'b0;
    #1;
    check_val("rst_busy", d_busy, 0);
    check_val("rst_hsync", d_hs, 1);
    check_val("rst_vsync", d_vs, 1);
    check_val("rst_video", d_vid, 0);
    check_val("rst_x", d_x, 0);
    check_val("rst_y", d_y, 0);
    check_val("rst_pulses", {d_tick, d_line, d_frame}, 0);
    check_val("rst_full_busy", f_busy, 0);
    repeat (3) step();
    rst_i = 1'b1;

    bad_d = 0;
    bad_f = 0;
    repeat (100) begin
      step();
      if (d_busy || !d_hs || !d_vs || d_vid || d_x != 0 || d_y != 0 || d_tick || d_line || d_frame) bad_d++;
      if (f_busy || !f_hs || !f_vs || f_vid || f_x != 0 || f_y != 0 || f_tick || f_line || f_frame) bad_f++;
    end
    check_val("idle_hold_small", bad_d, 0);
    check_val("idle_hold_full", bad_f, 0);

    // Start scan; k counts edges after en_i is first sampled high
    en_i = 1'b1;
    last_tick_d = -1; bad_tick_d = 0; n_tick_d = 0;
    last_line_d = 0;  bad_line_d = 0; n_line_d = 0;
    last_frame_d = 0; bad_frame_d = 0; n_frame_d = 0; first_frame_d = -1;
    hs_low_d = 0; vs_low_d = 0; vid_d = 0; hs_first_x_d = -1; vs_first_y_d = -1;
    last_tick_f = -1; bad_tick_f = 0; n_tick_f = 0; n_line_f = 0; line_k_f = -1; n_frame_f = 0;
    hs_low_f = 0; vs_low_f = 0; vid_f = 0; hs_first_x_f = -1; hs_last_x_f = -1;
    for (int k = 0; k <= 3300; k++) begin
      step();
      if (k == 0) begin
        check_val("start_frame", d_frame, 1);
        check_val("start_video", d_vid, 1);
        check_val("start_busy", d_busy, 1);
        check_val("start_xy", {d_x, d_y}, 0);
        check_val("start_tick", d_tick, 0);
        check_val("start_full_frame", f_frame, 1);
        check_val("start_full_video", f_vid, 1);
      end
      if (k == 1) check_val("k1_frame_low", d_frame, 0);
      if (k == 2) begin
        check_val("k2_tick", d_tick, 1);
        check_val("k2_x", d_x, 1);
      end
      if (k == 3) check_val("full_k3_x", f_x, 0);
      if (k == 4) begin
        check_val("full_k4_tick", f_tick, 1);
        check_val("full_k4_x", f_x, 1);
      end
      if (d_tick) begin
        if (last_tick_d >= 0 && k - last_tick_d != 2) bad_tick_d++;
        last_tick_d = k;
        n_tick_d++;
      end
      if (d_line) begin
        if (k - last_line_d != 30) bad_line_d++;
        last_line_d = k;
        n_line_d++;
      end
      if (d_frame && k > 0) begin
        if (k - last_frame_d != 300) bad_frame_d++;
        if (first_frame_d < 0) first_frame_d = k;
        last_frame_d = k;
        n_frame_d++;
      end
      if (k < 300) begin
        if (!d_hs) begin
          if (hs_first_x_d < 0) hs_first_x_d = int'(d_x);
          hs_low_d++;
        end
        if (!d_vs) begin
          if (vs_first_y_d < 0) vs_first_y_d = int'(d_y);
          vs_low_d++;
        end
        if (d_vid) vid_d++;
      end
      if (f_tick) begin
        if (last_tick_f >= 0 && k - last_tick_f != 4) bad_tick_f++;
        last_tick_f = k;
        n_tick_f++;
      end
      if (f_line) begin
        n_line_f++;
        line_k_f = k;
      end
      if (f_frame && k > 0) n_frame_f++;
      if (k < 3200) begin
        if (!f_hs) begin
          if (hs_first_x_f < 0) hs_first_x_f = int'(f_x);
          hs_last_x_f = int'(f_x);
          hs_low_f++;
        end
        if (!f_vs) vs_low_f++;
        if (f_vid) vid_f++;
      end
    end
    check_val("tick_count", n_tick_d, 1650);
    check_val("tick_period", bad_tick_d, 0);
    check_val("line_count", n_line_d, 110);
    check_val("line_period", bad_line_d, 0);
    check_val("frame_count", n_frame_d, 11);
    check_val("frame_first", first_frame_d, 300);
    check_val("frame_period", bad_frame_d, 0);
    check_val("hsync_low_cycles", hs_low_d, 60);
    check_val("hsync_first_x", hs_first_x_d, 10);
    check_val("vsync_low_cycles", vs_low_d, 60);
    check_val("vsync_first_y", vs_first_y_d, 7);
    check_val("video_cycles", vid_d, 96);
    check_val("full_tick_count", n_tick_f, 825);
    check_val("full_tick_period", bad_tick_f, 0);
    check_val("full_line_count", n_line_f, 1);
    check_val("full_line_k", line_k_f, 3200);
    check_val("full_no_frame", n_frame_f, 0);
    check_val("full_hsync_cycles", hs_low_f, 384);
    check_val("full_hsync_first_x", hs_first_x_f, 656);
    check_val("full_hsync_last_x", hs_last_x_f, 751);
    check_val("full_vsync_cycles", vs_low_f, 0);
    check_val("full_video_cycles", vid_f, 2560);

    // Drop en_i at line 3: drain to the end of the frame, then idle
    kc = 3300;
    guard = 0;
    while (d_y != 3 && guard < 200) begin step(); kc++; guard++; end
    check_val("drain_reach_line3", kc, 3390);
    en_i = 1'b0;
    n_frame_extra = 0;
    guard = 0;
    while (d_busy && guard < 400) begin
      step(); kc++; guard++;
      if (d_frame) n_frame_extra++;
    end
    check_val("drain_end_k", kc, 3600);
    check_val("drain_no_frame", n_frame_extra, 0);
    check_val("drain_idle_syncs", {d_hs, d_vs}, 3);
    check_val("drain_idle_video", d_vid, 0);
    check_val("drain_idle_xy", {d_x, d_y}, 0);
    bad_d = 0;
    repeat (10) begin
      step();
      if (d_busy || d_frame || d_tick || d_x != 0) bad_d++;
    end
    check_val("drain_idle_hold", bad_d, 0);

    // Drop en_i at line 3, restore at line 7: scan must not be disturbed
    en_i = 1'b1;
    step(); kc = 0;
    check_val("resume_start_frame", d_frame, 1);
    guard = 0;
    while (d_y != 3 && guard < 200) begin step(); kc++; guard++; end
    check_val("resume_line3_k", kc, 90);
    en_i = 1'b0;
    guard = 0;
    while (d_y != 7 && guard < 200) begin step(); kc++; guard++; end
    check_val("resume_line7_k", kc, 210);
    en_i = 1'b1;
    n_busy_low = 0;
    n_frame_extra = 0;
    while (kc < 300) begin
      step(); kc++;
      if (!d_busy) n_busy_low++;
      if (d_frame && kc < 300) n_frame_extra++;
      if (kc == 211) check_val("resume_pos_211", {d_x, d_y}, {10'd0, 10'd7});
    end
    check_val("resume_busy_gap", n_busy_low, 0);
    check_val("resume_early_frame", n_frame_extra, 0);
    check_val("resume_frame_on_time", d_frame, 1);
    check_val("resume_frame_xy", {d_x, d_y}, 0);

    // en_i low exactly on the final tick while in RUN: straight to IDLE
    while (kc < 599) begin step(); kc++; end
    check_val("final_pos", {d_x, d_y}, {10'd14, 10'd9});
    check_val("final_busy_before", d_busy, 1);
    en_i = 1'b0;
    step(); kc++;
    check_val("final_idle_busy", d_busy, 0);
    check_val("final_idle_frame", d_frame, 0);
    check_val("final_idle_xy", {d_x, d_y}, 0);
    check_val("final_idle_hsync", d_hs, 1);

    // Asynchronous reset mid-frame at (4,3) with en_i held high
    step();
    en_i = 1'b1;
    step(); kc = 0;
    check_val("rst_test_start_frame", d_frame, 1);
    guard = 0;
    while (!(d_x == 4 && d_y == 3) && guard < 300) begin step(); kc++; guard++; end
    check_val("rst_test_reach_k", kc, 98);
    #3 rst_i = 1'b0;
    #1;
    check_val("midrst_xy", {d_x, d_y}, 0);
    check_val("midrst_busy", d_busy, 0);
    check_val("midrst_syncs", {d_hs, d_vs}, 3);
    check_val("midrst_video", d_vid, 0);
    check_val("midrst_pulses", {d_tick, d_line, d_frame}, 0);
    check_val("midrst_full_busy", f_busy, 0);
    #3 rst_i = 1'b1;
    step();
    check_val("rerun_frame", d_frame, 1);
    check_val("rerun_xy", {d_x, d_y}, 0);
    check_val("rerun_video", d_vid, 1);
    check_val("rerun_busy", d_busy, 1);
    step();
    step();
    check_val("rerun_tick", d_tick, 1);
    check_val("rerun_x1", d_x, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
